// File: rtl/mux_sched_pkg.sv
// Shared types and default sizing for the round-robin mux scheduler.
package mux_sched_pkg;

    localparam int NUM_REQ_DEF = 31;
    localparam int DATA_W_DEF  = 2;
    localparam int SEL_W_DEF   = 5;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SELECT  = 2'd1,
        CAPTURE = 2'd2,
        HOLD    = 2'd3
    } state_t;

endpackage

// File: rtl/mux_rr_scheduler_rr_pick.sv
// Combinational round-robin picker: first set request at or above rr_ptr, wrapping.
module rr_pick
    import mux_sched_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEF,
    parameter int SEL_W   = SEL_W_DEF
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [SEL_W-1:0]   rr_ptr,
    output logic               any_req,
    output logic [SEL_W-1:0]   winner
);

    logic [NUM_REQ-1:0] rot;
    logic [SEL_W-1:0]   offset;
    logic [SEL_W:0]     sum;

    assign any_req = |req;

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
        offset = '0;
        // Rotating the doubled vector puts rr_ptr at bit 0; wrap-around comes for free.
        rot = NUM_REQ'({req, req} >> rr_ptr);
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (rot[i]) begin
                offset = SEL_W'(i);
            end
        end
        sum = {1'b0, rr_ptr} + {1'b0, offset};
        if (sum >= (SEL_W + 1)'(NUM_REQ)) begin
            sum = sum - (SEL_W + 1)'(NUM_REQ);
        end
        winner = sum[SEL_W-1:0];
    end

endmodule

// File: rtl/mux_rr_scheduler.sv
// Round-robin scheduler driving a shared combinational mux and returning
// the selected data through a valid/ready port.
module mux_rr_scheduler
    import mux_sched_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int SEL_W   = SEL_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] gnt,
    output logic [SEL_W-1:0]   mux_sel,
    input  logic [DATA_W-1:0]  mux_out,
    output logic [DATA_W-1:0]  data_out,
    output logic [SEL_W-1:0]   src_id,
    output logic               data_valid,
    input  logic               data_ready
);

    state_t           state;
    state_t           state_next;
    logic [SEL_W-1:0] rr_ptr;
    logic [SEL_W-1:0] ptr_next;
    logic             any_req;
    logic [SEL_W-1:0] winner;
    logic             accept;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .SEL_W   (SEL_W)
    ) u_rr_pick (
        .req     (req),
        .rr_ptr  (rr_ptr),
        .any_req (any_req),
        .winner  (winner)
    );

    assign accept   = data_valid && data_ready;
    assign ptr_next = (mux_sel == SEL_W'(NUM_REQ - 1)) ? '0 : mux_sel + SEL_W'(1);

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (any_req) state_next = SELECT;
            SELECT:  state_next = CAPTURE;
            CAPTURE: state_next = HOLD;
            HOLD:    if (accept) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        gnt = '0;
        if (state == CAPTURE) begin
            gnt = NUM_REQ'(1) << mux_sel;
        end
    end

    // The served requester drops to lowest priority by moving rr_ptr just past it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mux_sel    <= '0;
            data_out   <= '0;
            src_id     <= '0;
            data_valid <= 1'b0;
            rr_ptr     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        mux_sel <= winner;
                    end
                end
                CAPTURE: begin
                    data_out   <= mux_out;
                    src_id     <= mux_sel;
                    data_valid <= 1'b1;
                    rr_ptr     <= ptr_next;
                end
                HOLD: begin
                    if (accept) begin
                        data_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mux_rr_scheduler.sv
// Self-checking bench: directed vector table, hand-written corner sequences
// and randomized transfers against a transaction-level round-robin model.
module tb_mux_rr_scheduler;
    import mux_sched_pkg::*;

    localparam int N = NUM_REQ_DEF;
    localparam int D = DATA_W_DEF;
    localparam int S = SEL_W_DEF;

    logic         clk;
    logic         rst;
    logic [N-1:0] req;
    logic [N-1:0] gnt;
    logic [S-1:0] mux_sel;
    logic [D-1:0] mux_out;
    logic [D-1:0] data_out;
    logic [S-1:0] src_id;
    logic         data_valid;
    logic         data_ready;

    logic [D-1:0] mux_in [N];
    int           tests;
    int           fails;
    int           model_ptr;

    typedef struct {
        logic [N-1:0] req;
        int           delay;
        int           exp_src;
        int           exp_data;
    } vec_t;

    vec_t vecs [10];

    mux_rr_scheduler #(
        .NUM_REQ (N),
        .DATA_W  (D),
        .SEL_W   (S)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .gnt        (gnt),
        .mux_sel    (mux_sel),
        .mux_out    (mux_out),
        .data_out   (data_out),
        .src_id     (src_id),
        .data_valid (data_valid),
        .data_ready (data_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        mux_out = '0;
        if (int'(mux_sel) < N) mux_out = mux_in[mux_sel];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at time %0t", name, act, exp, $time);
        end
    endtask

    function automatic int ref_winner(input logic [N-1:0] r, input int ptr);
        for (int k = 0; k < N; k++) begin
            if (r[(ptr + k) % N]) return (ptr + k) % N;
        end
        return -1;
    endfunction

    always @(negedge clk) begin
        check("sel_in_range", (int'(mux_sel) < N) ? 32'd1 : 32'd0, 32'd1);
        check("gnt_onehot0", $onehot0(gnt) ? 32'd1 : 32'd0, 32'd1);
    end

    // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle again.
    task automatic xfer(input logic [N-1:0] r, input int delay, input int exp_src,
                        input int exp_data, input bit drop);
        logic [N-1:0] exp_gnt;
        exp_gnt    = N'(1) << exp_src;
        req        = r;
        data_ready = 1'($urandom_range(0, 1));
        @(negedge clk);
        if (drop) req = '0;
        check("select_mux_sel", 32'(mux_sel), 32'(exp_src));
        check("select_gnt", 32'(gnt), 32'd0);
        check("select_valid", 32'(data_valid), 32'd0);
        @(negedge clk);
        check("capture_gnt", 32'(gnt), 32'(exp_gnt));
        check("capture_valid", 32'(data_valid), 32'd0);
        data_ready = 1'b0;
        @(negedge clk);
        check("hold_valid", 32'(data_valid), 32'd1);
        check("hold_data", 32'(data_out), 32'(exp_data));
        check("hold_src", 32'(src_id), 32'(exp_src));
        check("hold_gnt", 32'(gnt), 32'd0);
        for (int k = 0; k < delay; k++) begin
            data_ready = 1'b0;
            @(negedge clk);
            check("stall_valid", 32'(data_valid), 32'd1);
            check("stall_data", 32'(data_out), 32'(exp_data));
            check("stall_src", 32'(src_id), 32'(exp_src));
            check("stall_gnt", 32'(gnt), 32'd0);
        end
        data_ready = 1'b1;
        @(negedge clk);
        check("accept_valid_clear", 32'(data_valid), 32'd0);
        req        = '0;
        data_ready = 1'b0;
        model_ptr  = (exp_src + 1) % N;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tests      = 0;
        fails      = 0;
        model_ptr  = 0;
        rst        = 1'b1;
        req        = '0;
        data_ready = 1'b0;
        for (int i = 0; i < N; i++) mux_in[i] = D'(i % 4);
        mux_in[12] = 2'b10;

        vecs[0] = '{N'(1) << 12,                   2, 12, 2};
        vecs[1] = '{(N'(1) << 3) | (N'(1) << 20),  5, 20, 0};
        vecs[2] = '{(N'(1) << 3) | (N'(1) << 20),  0,  3, 3};
        vecs[3] = '{(N'(1) << 3) | (N'(1) << 4),   1,  4, 0};
        vecs[4] = '{N'(1) << 29,                   0, 29, 1};
        vecs[5] = '{(N'(1) << 30) | N'(1),         0, 30, 2};
        vecs[6] = '{(N'(1) << 30) | N'(1),         0,  0, 0};
        vecs[7] = '{{N{1'b1}},                     0,  1, 1};
        vecs[8] = '{N'(3),                         2,  0, 0};
        vecs[9] = '{N'(1) << 1,                    0,  1, 1};

        repeat (3) @(negedge clk);
        check("reset_mux_sel", 32'(mux_sel), 32'd0);
        check("reset_data_out", 32'(data_out), 32'd0);
        check("reset_src_id", 32'(src_id), 32'd0);
        check("reset_valid", 32'(data_valid), 32'd0);
        check("reset_gnt", 32'(gnt), 32'd0);
        rst = 1'b0;

        for (int v = 0; v < 10; v++) begin
            xfer(vecs[v].req, vecs[v].delay, vecs[v].exp_src, vecs[v].exp_data, 1'b0);
        end

        // Request present only during the arbitration cycle still completes.
        xfer(N'(1) << 5, 0, 5, 1, 1'b1);
        repeat (4) begin
            @(negedge clk);
            check("post_pulse_gnt", 32'(gnt), 32'd0);
            check("post_pulse_valid", 32'(data_valid), 32'd0);
            check("post_pulse_sel_hold", 32'(mux_sel), 32'd5);
        end

        // Asynchronous reset during SELECT loses the transfer and rewinds the pointer.
        req = (N'(1) << 7) | (N'(1) << 2);
        @(negedge clk);
        check("pre_rst_sel", 32'(mux_sel), 32'd7);
        #2 rst = 1'b1;
        #1;
        check("async_rst_sel", 32'(mux_sel), 32'd0);
        check("async_rst_src", 32'(src_id), 32'd0);
        check("async_rst_data", 32'(data_out), 32'd0);
        check("async_rst_valid", 32'(data_valid), 32'd0);
        check("async_rst_gnt", 32'(gnt), 32'd0);
        repeat (3) begin
            @(negedge clk);
            check("in_rst_gnt", 32'(gnt), 32'd0);
        end
        rst       = 1'b0;
        model_ptr = 0;
        xfer((N'(1) << 7) | (N'(1) << 2), 0, 2, 2, 1'b0);
        xfer(N'(1) << 7, 0, 7, 3, 1'b0);

        // All requesters held: strict rotation from 0 with wrap.
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst       = 1'b0;
        model_ptr = 0;
        for (int i = 0; i < N; i++) mux_in[i] = D'(i % 4);
        for (int k = 0; k <= N; k++) begin
            xfer({N{1'b1}}, 0, k % N, (k % N) % 4, 1'b0);
        end

        for (int it = 0; it < 150; it++) begin
            logic [N-1:0] r;
            int           w;
            r = N'($urandom);
            case ($urandom_range(0, 3))
                0:       r = r & N'($urandom) & N'($urandom);
                1:       r = N'(1) << $urandom_range(0, N - 1);
                default: ;
            endcase
            if ($urandom_range(0, 9) == 0) r = '0;
            for (int i = 0; i < N; i++) mux_in[i] = D'($urandom);
            if (r == '0) begin
                req = '0;
                @(negedge clk);
                check("rand_idle_gnt", 32'(gnt), 32'd0);
                check("rand_idle_valid", 32'(data_valid), 32'd0);
            end else begin
                w = ref_winner(r, model_ptr);
                xfer(r, $urandom_range(0, 3), w, int'(mux_in[w]), $urandom_range(0, 3) == 0);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
